serial_cfg_lut_bank: RTL

- Bank of NUM_LUTS independent lookup tables, each IN_WIDTH -> OUT_WIDTH, configured over a single serial config port.
- Config is shifted into a shadow register and committed atomically to the active table only after a frame of exactly TABLE_BITS bits. Lookups never see a half-loaded table.
- Shadow MSB is exposed as serial out for readback and daisy-chaining of several banks.
- Successor to the single-LUT serial loader. Used wherever the design needs field-programmable combinational functions with registered outputs.

---
 rtl/serial_cfg_lut_bank.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_cfg_lut_bank.sv
// Bank of NUM_LUTS registered lookup tables loaded through one serial shadow
// register; a frame is committed to the active table only if it is exactly TABLE_BITS long.
module serial_cfg_lut_bank #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int NUM_LUTS  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_d,
  input  logic                          cfg_cs_n,
  output logic                          cfg_q,
  input  logic [NUM_LUTS*IN_WIDTH-1:0]  sel,
  output logic [NUM_LUTS*OUT_WIDTH-1:0] lut_out,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic                          table_valid
);

  localparam int ENTRIES    = 2 ** IN_WIDTH;
  localparam int TABLE_BITS = NUM_LUTS * ENTRIES * OUT_WIDTH;
  localparam int CNT_W      = $clog2(TABLE_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TABLE_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TABLE_BITS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [TABLE_BITS-1:0]         shadow_q, shadow_d;
  logic [TABLE_BITS-1:0]         active_q, active_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_LUTS*OUT_WIDTH-1:0] lut_out_q, lut_out_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          valid_q, valid_d;

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        if (!cfg_cs_n) begin
          shadow_d = {shadow_q[TABLE_BITS-2:0], cfg_d};
          cnt_d    = CNT_ONE;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!cfg_cs_n) begin
          shadow_d = {shadow_q[TABLE_BITS-2:0], cfg_d};
          // Saturating one past full keeps overrun frames distinguishable.
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            active_d = shadow_q;
            done_d   = 1'b1;
            err_d    = 1'b0;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lookup reads the registered active table, so a commit edge still returns old data.
  always_comb begin
    lut_out_d = '0;
    for (int k = 0; k < NUM_LUTS; k++) begin
      lut_out_d[k*OUT_WIDTH +: OUT_WIDTH] =
        active_q[(k*ENTRIES + int'(sel[k*IN_WIDTH +: IN_WIDTH]))*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from pre-edge values, independent of statement order.
  // NOTE: the active table is reset because lookups must return a defined 0 before the first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      lut_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      lut_out_q <= lut_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign cfg_q       = shadow_q[TABLE_BITS-1];
  assign lut_out     = lut_out_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign table_valid = valid_q;

endmodule
